// File: rtl/core_mdu_pkg.sv
// Shared types for the execute-stage multiply/divide controller.
// Op encoding matches the M-extension funct3 ordering used by the decoder.
package core_mdu_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StClear,
    StResp
  } mdu_ctrl_state_t;

  function automatic logic is_div_op(input mdu_op_t op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  function automatic logic is_rem_op(input mdu_op_t op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/core_mdu_result_cache.sv
// Single-entry last-result cache: stores {op, word, rs1, rs2} and the MDU result.
// Entries are pure functions of their key, so only reset clears the valid bit.
module core_mdu_result_cache #(
  parameter int unsigned XLEN     = 64,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  input  logic                 i_wr,
  input  logic [4+2*XLEN-1:0]  i_wr_key,
  input  logic [XLEN-1:0]      i_wr_data,
  input  logic [4+2*XLEN-1:0]  i_lookup_key,
  output logic                 o_hit,
  output logic [XLEN-1:0]      o_data
);

  if (CACHE_EN) begin : g_cache
    logic                r_valid;
    logic [4+2*XLEN-1:0] r_key;
    logic [XLEN-1:0]     r_data;

    always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
        r_valid <= 1'b0;
        r_key   <= '0;
        r_data  <= '0;
      end else if (i_wr) begin
        r_valid <= 1'b1;
        r_key   <= i_wr_key;
        r_data  <= i_wr_data;
      end
    end

    assign o_hit  = r_valid && (r_key == i_lookup_key);
    assign o_data = r_data;
  end else begin : g_nocache
    assign o_hit  = 1'b0;
    assign o_data = '0;
  end

endmodule

// File: rtl/core_pipe_exec_mdu_ctrl.sv
// Sequences one M-extension op at a time into the iterative MDU, short-circuiting
// divide-by-zero and exact repeats, and clearing the MDU's sticky done after each result.
module core_pipe_exec_mdu_ctrl
  import core_mdu_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [4:0]      rsp_rd,
  output logic            mdu_valid,
  output logic            mdu_flush,
  output logic            mdu_op_word,
  output logic            mdu_op_mul,
  output logic            mdu_op_mulh,
  output logic            mdu_op_mulhu,
  output logic            mdu_op_mulhsu,
  output logic            mdu_op_div,
  output logic            mdu_op_divu,
  output logic            mdu_op_rem,
  output logic            mdu_op_remu,
  output logic [XLEN-1:0] mdu_rs1,
  output logic [XLEN-1:0] mdu_rs2,
  input  logic            mdu_ready,
  input  logic [XLEN-1:0] mdu_rd,
  output logic            busy
);

  mdu_ctrl_state_t r_state, w_state_d;

  mdu_op_t         r_op;
  logic            r_word;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_result;

  mdu_op_t         w_req_op;
  logic            w_accept;
  logic            w_divisor_zero;
  logic            w_dz;
  logic [XLEN-1:0] w_dz_result;
  logic            w_cache_wr;
  logic            w_hit;
  logic [XLEN-1:0] w_hit_data;
  logic [4+2*XLEN-1:0] w_lookup_key;
  logic [4+2*XLEN-1:0] w_wr_key;

  assign w_req_op  = mdu_op_t'(req_op);
  assign req_ready = (r_state == StIdle) && !flush;
  assign w_accept  = req_ready && req_valid;

  // W-form divides only look at the low word of the divisor.
  assign w_divisor_zero = req_word ? (req_rs2[31:0] == 32'd0) : (req_rs2 == '0);
  assign w_dz = (is_div_op(w_req_op) || is_rem_op(w_req_op)) && w_divisor_zero;

  always_comb begin
    w_dz_result = '1;
    if (is_rem_op(w_req_op)) begin
      w_dz_result = req_word ? {{(XLEN-32){req_rs1[31]}}, req_rs1[31:0]} : req_rs1;
    end
  end

  assign w_lookup_key = {req_op, req_word, req_rs1, req_rs2};
  assign w_wr_key     = {r_op, r_word, r_rs1, r_rs2};
  // A result arriving in a flush cycle belongs to an aborted op and is dropped.
  assign w_cache_wr   = (r_state == StRun) && mdu_ready && !flush;

  core_mdu_result_cache #(
    .XLEN     (XLEN),
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .g_clk        (g_clk),
    .g_reset      (g_reset),
    .i_wr         (w_cache_wr),
    .i_wr_key     (w_wr_key),
    .i_wr_data    (mdu_rd),
    .i_lookup_key (w_lookup_key),
    .o_hit        (w_hit),
    .o_data       (w_hit_data)
  );

  always_comb begin
    w_state_d = r_state;
    if (flush) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (w_accept) w_state_d = (w_dz || w_hit) ? StResp : StRun;
        StRun:   if (mdu_ready) w_state_d = StClear;
        StClear: w_state_d = rsp_ready ? StIdle : StResp;
        StResp:  if (rsp_ready) w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_op     <= OpMul;
      r_word   <= 1'b0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= w_req_op;
        r_word <= req_word;
        r_rs1  <= req_rs1;
        r_rs2  <= req_rs2;
        r_rd   <= req_rd;
        if (w_dz) begin
          r_result <= w_dz_result;
        end else if (w_hit) begin
          r_result <= w_hit_data;
        end
      end
      if (w_cache_wr) begin
        r_result <= mdu_rd;
      end
    end
  end

  always_comb begin
    mdu_op_mul    = 1'b0;
    mdu_op_mulh   = 1'b0;
    mdu_op_mulhsu = 1'b0;
    mdu_op_mulhu  = 1'b0;
    mdu_op_div    = 1'b0;
    mdu_op_divu   = 1'b0;
    mdu_op_rem    = 1'b0;
    mdu_op_remu   = 1'b0;
    if (r_state != StIdle) begin
      unique case (r_op)
        OpMul:    mdu_op_mul    = 1'b1;
        OpMulh:   mdu_op_mulh   = 1'b1;
        OpMulhsu: mdu_op_mulhsu = 1'b1;
        OpMulhu:  mdu_op_mulhu  = 1'b1;
        OpDiv:    mdu_op_div    = 1'b1;
        OpDivu:   mdu_op_divu   = 1'b1;
        OpRem:    mdu_op_rem    = 1'b1;
        OpRemu:   mdu_op_remu   = 1'b1;
        default:  mdu_op_mul    = 1'b0;
      endcase
    end
  end

  assign mdu_valid   = (r_state == StRun);
  assign mdu_flush   = flush || (r_state == StClear);
  assign mdu_op_word = r_word;
  assign mdu_rs1     = r_rs1;
  assign mdu_rs2     = r_rs2;
  assign rsp_valid   = (r_state == StClear) || (r_state == StResp);
  assign rsp_data    = r_result;
  assign rsp_rd      = r_rd;
  assign busy        = (r_state != StIdle);

endmodule

// File: tb/tb_core_pipe_exec_mdu_ctrl.sv
// Directed bench for the MDU controller with a small latency-programmable MDU model.
module tb_core_pipe_exec_mdu_ctrl;

  localparam int XLEN = 64;

  logic            g_clk = 1'b0;
  logic            g_reset = 1'b1;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_op = 3'd0;
  logic            req_word = 1'b0;
  logic [XLEN-1:0] req_rs1 = '0;
  logic [XLEN-1:0] req_rs2 = '0;
  logic [4:0]      req_rd = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [XLEN-1:0] rsp_data;
  logic [4:0]      rsp_rd;
  logic            mdu_valid, mdu_flush, mdu_op_word;
  logic            mdu_op_mul, mdu_op_mulh, mdu_op_mulhu, mdu_op_mulhsu;
  logic            mdu_op_div, mdu_op_divu, mdu_op_rem, mdu_op_remu;
  logic [XLEN-1:0] mdu_rs1, mdu_rs2;
  logic            mdu_ready;
  logic [XLEN-1:0] mdu_rd;
  logic            busy;

  int n_pass = 0;
  int n_total = 0;

  // MDU model: result ready on the m_lat-th cycle of mdu_valid.
  int          m_lat = 4;
  int          m_cnt;
  int          m_vcnt;
  int          f_cnt;

  always #5 g_clk = ~g_clk;

  always @(posedge g_clk or posedge g_reset) begin
    if (g_reset) m_cnt <= 0;
    else if (mdu_valid && !mdu_ready) m_cnt <= m_cnt + 1;
    else m_cnt <= 0;
  end

  always @(posedge g_clk) begin
    if (mdu_valid) m_vcnt <= m_vcnt + 1;
    if (mdu_flush) f_cnt <= f_cnt + 1;
  end

  assign mdu_ready = mdu_valid && (m_cnt == m_lat - 1);

  always_comb begin
    mdu_rd = '0;
    if (mdu_op_mul) mdu_rd = mdu_rs1 * mdu_rs2;
    else if (mdu_op_div || mdu_op_divu) mdu_rd = (mdu_rs2 == 0) ? '1 : mdu_rs1 / mdu_rs2;
    else if (mdu_op_rem || mdu_op_remu) mdu_rd = (mdu_rs2 == 0) ? mdu_rs1 : mdu_rs1 % mdu_rs2;
  end

  core_pipe_exec_mdu_ctrl #(.XLEN(XLEN), .CACHE_EN(1'b1)) dut (
    .g_clk         (g_clk),
    .g_reset       (g_reset),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_word      (req_word),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_rd        (req_rd),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_rd        (rsp_rd),
    .mdu_valid     (mdu_valid),
    .mdu_flush     (mdu_flush),
    .mdu_op_word   (mdu_op_word),
    .mdu_op_mul    (mdu_op_mul),
    .mdu_op_mulh   (mdu_op_mulh),
    .mdu_op_mulhu  (mdu_op_mulhu),
    .mdu_op_mulhsu (mdu_op_mulhsu),
    .mdu_op_div    (mdu_op_div),
    .mdu_op_divu   (mdu_op_divu),
    .mdu_op_rem    (mdu_op_rem),
    .mdu_op_remu   (mdu_op_remu),
    .mdu_rs1       (mdu_rs1),
    .mdu_rs2       (mdu_rs2),
    .mdu_ready     (mdu_ready),
    .mdu_rd        (mdu_rd),
    .busy          (busy)
  );

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd, output logic acc);
    req_valid = 1'b1;
    req_op    = op;
    req_word  = w;
    req_rs1   = a;
    req_rs2   = b;
    req_rd    = rd;
    #1 acc = req_ready;
    @(negedge g_clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < max) begin
      @(negedge g_clk);
      cyc++;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge g_clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (mdu_valid !== 1'b0) $display("FAIL rst_mdu_valid: got %b want 0", mdu_valid); else n_pass++;
    n_total++; if (mdu_flush !== 1'b0) $display("FAIL rst_mdu_flush: got %b want 0", mdu_flush); else n_pass++;
    n_total++; if (rsp_data !== 64'd0) $display("FAIL rst_rsp_data: got %h want 0", rsp_data); else n_pass++;
    n_total++;
    if ({mdu_op_mul, mdu_op_mulh, mdu_op_mulhsu, mdu_op_mulhu, mdu_op_div, mdu_op_divu,
         mdu_op_rem, mdu_op_remu} !== 8'd0)
      $display("FAIL rst_onehot: got nonzero want 00");
    else n_pass++;
    @(negedge g_clk);
    g_reset = 1'b0;
    @(negedge g_clk);
    n_total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_mul();
    logic acc;
    int   cyc;
    m_lat = 17; m_vcnt = 0; f_cnt = 0;
    issue(3'd0, 1'b0, 64'd7, 64'd6, 5'd5, acc);
    n_total++; if (acc !== 1'b1) $display("FAIL mul_accept: got %b want 1", acc); else n_pass++;
    n_total++; if (mdu_valid !== 1'b1) $display("FAIL mul_mdu_valid: got %b want 1", mdu_valid); else n_pass++;
    n_total++; if (mdu_op_mul !== 1'b1) $display("FAIL mul_onehot: got %b want 1", mdu_op_mul); else n_pass++;
    wait_rsp(100, cyc);
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL mul_rsp_timeout: got %b want 1", rsp_valid); else n_pass++;
    n_total++; if (cyc !== 17) $display("FAIL mul_latency: got %0d want 17", cyc); else n_pass++;
    n_total++; if (mdu_flush !== 1'b1) $display("FAIL mul_clear_flush: got %b want 1", mdu_flush); else n_pass++;
    n_total++; if (rsp_data !== 64'd42) $display("FAIL mul_data: got %h want %h", rsp_data, 64'd42); else n_pass++;
    n_total++; if (rsp_rd !== 5'd5) $display("FAIL mul_rd: got %0d want 5", rsp_rd); else n_pass++;
    ack();
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL mul_rsp_drop: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (f_cnt !== 1) $display("FAIL mul_flush_cycles: got %0d want 1", f_cnt); else n_pass++;
    n_total++; if (m_vcnt !== 17) $display("FAIL mul_valid_cycles: got %0d want 17", m_vcnt); else n_pass++;
  endtask

  task automatic test_div_zero();
    logic acc;
    int   cyc;
    m_vcnt = 0;
    issue(3'd5, 1'b1, 64'h1234, 64'hFFFF_FFFF_0000_0000, 5'd3, acc);
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL divuw0_rsp_valid: got %b want 1", rsp_valid); else n_pass++;
    n_total++;
    if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL divuw0_data: got %h want ffffffffffffffff", rsp_data);
    else n_pass++;
    ack();
    issue(3'd6, 1'b1, 64'h8000_0000, 64'd0, 5'd4, acc);
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL remw0_rsp_valid: got %b want 1", rsp_valid); else n_pass++;
    n_total++;
    if (rsp_data !== 64'hFFFF_FFFF_8000_0000)
      $display("FAIL remw0_data: got %h want ffffffff80000000", rsp_data);
    else n_pass++;
    n_total++; if (rsp_rd !== 5'd4) $display("FAIL remw0_rd: got %0d want 4", rsp_rd); else n_pass++;
    ack();
    n_total++; if (m_vcnt !== 0) $display("FAIL dz_no_mdu: got %0d want 0", m_vcnt); else n_pass++;
    // Full-width divide: low word of divisor is zero but the divisor is not.
    m_lat = 2;
    issue(3'd4, 1'b0, 64'h3_0000_0000, 64'h1_0000_0000, 5'd6, acc);
    n_total++; if (mdu_valid !== 1'b1) $display("FAIL div64_runs_mdu: got %b want 1", mdu_valid); else n_pass++;
    wait_rsp(50, cyc);
    n_total++; if (rsp_data !== 64'd3) $display("FAIL div64_data: got %h want 3", rsp_data); else n_pass++;
    ack();
  endtask

  task automatic test_cache();
    logic acc;
    int   cyc;
    m_lat = 5;
    issue(3'd4, 1'b0, 64'd100, 64'd7, 5'd8, acc);
    wait_rsp(50, cyc);
    n_total++; if (rsp_data !== 64'd14) $display("FAIL div_data: got %h want 14", rsp_data); else n_pass++;
    ack();
    m_vcnt = 0;
    issue(3'd4, 1'b0, 64'd100, 64'd7, 5'd9, acc);
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL hit_rsp_valid: got %b want 1", rsp_valid); else n_pass++;
    n_total++; if (rsp_data !== 64'd14) $display("FAIL hit_data: got %h want 14", rsp_data); else n_pass++;
    n_total++; if (rsp_rd !== 5'd9) $display("FAIL hit_rd: got %0d want 9", rsp_rd); else n_pass++;
    ack();
    n_total++; if (m_vcnt !== 0) $display("FAIL hit_no_mdu: got %0d want 0", m_vcnt); else n_pass++;
    issue(3'd6, 1'b0, 64'd100, 64'd7, 5'd10, acc);
    n_total++; if (mdu_valid !== 1'b1) $display("FAIL rem_miss_mdu: got %b want 1", mdu_valid); else n_pass++;
    wait_rsp(50, cyc);
    n_total++; if (rsp_data !== 64'd2) $display("FAIL rem_data: got %h want 2", rsp_data); else n_pass++;
    ack();
  endtask

  task automatic test_flush();
    logic acc;
    int   cyc;
    m_lat = 20;
    issue(3'd4, 1'b0, 64'd200, 64'd9, 5'd11, acc);
    repeat (4) @(negedge g_clk);
    flush = 1'b1;
    #1;
    n_total++; if (mdu_flush !== 1'b1) $display("FAIL flush_mdu_flush: got %b want 1", mdu_flush); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL flush_req_ready: got %b want 0", req_ready); else n_pass++;
    @(negedge g_clk);
    flush = 1'b0;
    n_total++; if (mdu_valid !== 1'b0) $display("FAIL flush_mdu_valid: got %b want 0", mdu_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL flush_idle: got %b want 0", busy); else n_pass++;
    acc = 1'b0;
    repeat (3) begin
      @(negedge g_clk);
      if (rsp_valid) acc = 1'b1;
    end
    n_total++; if (acc !== 1'b0) $display("FAIL flush_no_rsp: got %b want 0", acc); else n_pass++;
    m_lat = 4;
    issue(3'd0, 1'b0, 64'd3, 64'd3, 5'd12, acc);
    wait_rsp(50, cyc);
    n_total++; if (rsp_data !== 64'd9) $display("FAIL post_flush_mul: got %h want 9", rsp_data); else n_pass++;
    ack();
    issue(3'd4, 1'b0, 64'd200, 64'd9, 5'd13, acc);
    n_total++; if (mdu_valid !== 1'b1) $display("FAIL aborted_no_hit: got %b want 1", mdu_valid); else n_pass++;
    wait_rsp(50, cyc);
    n_total++; if (rsp_data !== 64'd22) $display("FAIL aborted_rerun: got %h want 22", rsp_data); else n_pass++;
    ack();
  endtask

  task automatic test_back_pressure();
    logic acc;
    logic bad;
    int   cyc;
    m_lat = 3;
    issue(3'd0, 1'b0, 64'd12, 64'd11, 5'd17, acc);
    wait_rsp(50, cyc);
    bad = 1'b0;
    req_valid = 1'b1; req_op = 3'd0; req_rs1 = 64'd2; req_rs2 = 64'd2; req_rd = 5'd1;
    repeat (10) begin
      @(negedge g_clk);
      if (!rsp_valid || rsp_data !== 64'd132 || rsp_rd !== 5'd17 || req_ready) bad = 1'b1;
    end
    req_valid = 1'b0;
    n_total++; if (bad !== 1'b0) $display("FAIL bp_stable: got %b want 0", bad); else n_pass++;
    ack();
    n_total++; if (req_ready !== 1'b1) $display("FAIL bp_release: got %b want 1", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL bp_rsp_drop: got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic acc;
    int   cyc;
    issue(3'd0, 1'b0, 64'd12, 64'd11, 5'd2, acc);
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL pre_rst_hit: got %b want 1", rsp_valid); else n_pass++;
    ack();
    m_lat = 30;
    issue(3'd0, 1'b0, 64'd5, 64'd5, 5'd2, acc);
    repeat (3) @(negedge g_clk);
    #2 g_reset = 1'b1;
    #1;
    n_total++; if (mdu_valid !== 1'b0) $display("FAIL arst_mdu_valid: got %b want 0", mdu_valid); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL arst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    @(negedge g_clk);
    g_reset = 1'b0;
    @(negedge g_clk);
    m_lat = 4;
    issue(3'd0, 1'b0, 64'd12, 64'd11, 5'd2, acc);
    n_total++; if (mdu_valid !== 1'b1) $display("FAIL arst_cache_cleared: got %b want 1", mdu_valid); else n_pass++;
    wait_rsp(50, cyc);
    n_total++; if (rsp_data !== 64'd132) $display("FAIL arst_rerun: got %h want 132", rsp_data); else n_pass++;
    ack();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_zero();
    test_cache();
    test_flush();
    test_back_pressure();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
